// File: rtl/bit_ser_feed_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_ser_feed_if : operand handshake and serial adder drive lines
// Rev 1.0
// ---------------------------------------------------------------------------
interface bit_ser_feed_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ser_a;
  logic             ser_b;
  logic             add_clr_n;
  logic             add_set_n;
  logic             busy;
  logic             done;

  modport master (
    output start, op_a, op_b,
    input  ser_a, ser_b, add_clr_n, add_set_n, busy, done
  );

  modport slave (
    input  start, op_a, op_b,
    output ser_a, ser_b, add_clr_n, add_set_n, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bit_ser_feed.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_ser_feed : parallel-to-serial operand feeder for a bit-serial adder
// Rev 1.0
// ---------------------------------------------------------------------------
module bit_ser_feed #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     clr_n,
  bit_ser_feed_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ser_a_q, ser_a_d;
  logic               ser_b_q, ser_b_d;
  logic               add_clr_n_q, add_clr_n_d;
  logic               add_set_n_q, add_set_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Outputs are computed from the state being left at each edge, so the
  // adder sees each phase one cycle after the FSM enters it.
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    count_d     = count_q;
    ser_a_d     = 1'b0;
    ser_b_d     = 1'b0;
    add_clr_n_d = 1'b1;
    add_set_n_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.op_a;
          sb_d    = bus.op_b;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        add_clr_n_d = 1'b0;
        busy_d      = 1'b1;
        count_d     = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        // After WIDTH shifts the registers hold zero, giving the pad bit.
        ser_a_d = sa_q[0];
        ser_b_d = sb_q[0];
        busy_d  = 1'b1;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        if (count_q == CNT_W'(WIDTH)) begin
          count_d = '0;
          state_d = S_LATCH;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        add_set_n_d = 1'b0;
        busy_d      = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      count_q     <= '0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      add_clr_n_q <= 1'b1;
      add_set_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      count_q     <= count_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
      add_clr_n_q <= add_clr_n_d;
      add_set_n_q <= add_set_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ser_a     = ser_a_q;
  assign bus.ser_b     = ser_b_q;
  assign bus.add_clr_n = add_clr_n_q;
  assign bus.add_set_n = add_set_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_bit_ser_feed.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bit_ser_feed : directed and random checks of bit_ser_feed
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bit_ser_feed;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  bit_ser_feed_if #(.WIDTH(W)) bus ();

  bit_ser_feed #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: a transaction is a timeline of W+5 edges counted from acceptance.
  bit   m_act = 1'b0;
  int   m_k   = 0;
  int   m_a   = 0;
  int   m_b   = 0;

  // External serial adder fed by the DUT outputs.
  int   acc = 0;
  int   cy  = 0;
  int   idx = 0;
  int   done_seen = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packed as {ser_a, ser_b, add_clr_n, add_set_n, busy, done}
  function automatic int model_out();
    int bitn;
    if (!m_act || m_k == 0) return 6'b00_1_1_0_0;
    if (m_k == 1)           return 6'b00_0_1_1_0;
    if (m_k <= W + 2) begin
      bitn = m_k - 2;
      return (((m_a >> bitn) & 1) << 5) | (((m_b >> bitn) & 1) << 4) | 6'b00_1_1_1_0;
    end
    if (m_k == W + 3)       return 6'b00_1_0_1_0;
    return 6'b00_1_1_1_1;
  endfunction

  task automatic tick();
    bit idle;
    int s;
    @(posedge clk);
    if (!clr_n) begin
      m_act = 1'b0;
    end else begin
      idle = !m_act || (m_k == W + 4);
      if (idle && bus.start) begin
        m_act = 1'b1;
        m_k   = 0;
        m_a   = int'(bus.op_a);
        m_b   = int'(bus.op_b);
      end else if (idle) begin
        m_act = 1'b0;
      end else begin
        m_k++;
      end
    end
    #1;
    check("outputs", int'({bus.ser_a, bus.ser_b, bus.add_clr_n, bus.add_set_n,
                           bus.busy, bus.done}), model_out());
    if (bus.done) done_seen++;
    if (!bus.add_clr_n) begin
      acc = 0; cy = 0; idx = 0;
    end else if (!bus.add_set_n) begin
      check("adder_sum", acc, m_a + m_b);
    end else if (bus.busy && !bus.done) begin
      s   = int'(bus.ser_a) + int'(bus.ser_b) + cy;
      acc = acc | ((s & 1) << idx);
      cy  = s >> 1;
      idx++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset held from time 0 with start asserted
    bus.start = 1'b1;
    bus.op_a  = 8'h12;
    bus.op_b  = 8'h34;
    run(4);
    bus.start = 1'b0;
    clr_n     = 1'b1;
    run(2);

    // Basic sum 7 + 3
    done_seen = 0;
    bus.op_a = 8'h07; bus.op_b = 8'h03; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run(14);
    check("basic_done_count", done_seen, 1);

    // Carry flush FF + FF
    done_seen = 0;
    bus.op_a = 8'hFF; bus.op_b = 8'hFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run(14);
    check("flush_done_count", done_seen, 1);

    // Start re-asserted with new operands while shifting
    done_seen = 0;
    bus.op_a = 8'h3C; bus.op_b = 8'h0F; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run(4);
    bus.op_a = 8'h55; bus.op_b = 8'hAA; bus.start = 1'b1;
    run(3);
    bus.start = 1'b0;
    run(8);
    check("busy_start_done_count", done_seen, 1);

    // Back-to-back with start held high
    done_seen = 0;
    bus.op_a = 8'h01; bus.op_b = 8'h01; bus.start = 1'b1;
    run(26);
    bus.start = 1'b0;
    run(6);
    check("b2b_done_count", done_seen, 2);

    // Reset during SHIFT bit 4, then 0x80 + 0x80
    done_seen = 0;
    bus.op_a = 8'hA5; bus.op_b = 8'h5A; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run(6);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    run(14);
    check("reset_mid_done_count", done_seen, 0);
    bus.op_a = 8'h80; bus.op_b = 8'h80; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run(14);
    check("after_reset_done_count", done_seen, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op_a  = W'($urandom);
      bus.op_b  = W'($urandom);
      clr_n     = ($urandom_range(0, 59) != 0);
      tick();
    end
    clr_n     = 1'b1;
    bus.start = 1'b0;
    run(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
